core_boot_ctrl: RTL and testbench
=================================

# core_boot_ctrl

Boot and run-control stage between the peripheral subsystem's fetch-enable / boot-address / clock-gate outputs and the core region's control inputs. It holds the core off until the FLL reports a stable lock for a programmable number of cycles. It then forwards fetch-enable with a latched boot address and arbitrates clock-gating requests against core activity. Optionally, it detects loss of lock while running and parks the core.

## Interface
- LOCK_CYCLES, 16: consecutive cycles `fll_lock_i` must be high before the core may start; legal range ≥1.
- RESET_BOOT_ADDR, 32'h0000_0000: reset value of `boot_addr_o`.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- testmode_i  in  1  test mode; treats lock as always stable and forces `clk_en_o` high.
- fll_lock_i  in  1  FLL lock indication.
- fetch_enable_i  in  1  fetch enable from the peripheral subsystem.
- boot_addr_i  in  32  boot address from the peripheral subsystem.
- clk_gate_req_i  in  1  request to gate the core clock (1 = gate).
- core_busy_i  in  1  core busy indication.
- fetch_enable_o  out  1  fetch enable to the core region.
- boot_addr_o  out  32  boot address to the core region; stable while `fetch_enable_o`=1.
- clk_en_o  out  1  core clock enable to the core region's clock-gating input (1 = clock runs).
- ready_o  out  1  lock qualified; core may be started.
- lock_lost_o  out  1  sticky flag: lock dropped while RUN or GATED.

## Operation
- Reset values:
  - state = LOCK_WAIT, lock counter = 0.
  - fetch_enable_o = 0, boot_addr_o = RESET_BOOT_ADDR, clk_en_o = 1, ready_o = 0, lock_lost_o = 0.
- States: LOCK_WAIT, IDLE, RUN, GATED.
- LOCK_WAIT:
  - Counter increments on each cycle that lock is effective; lock is effective when `fll_lock_i`=1 or `testmode_i`=1.
  - Counter clears on any cycle without effective lock.
  - When lock is effective and the counter equals LOCK_CYCLES-1, go to IDLE and clear the counter.
  - Counter width is $clog2(LOCK_CYCLES+1) and the counter saturates; no wrap-around.
- IDLE:
  - ready_o = 1.
  - On `fetch_enable_i`=1: latch `boot_addr_i` into `boot_addr_o`, go to RUN, and set `fetch_enable_o`=1 on the same edge.
- RUN:
  - `fetch_enable_i`=0 → go to IDLE and clear `fetch_enable_o`.
  - Otherwise, `clk_gate_req_i`=1 and `core_busy_i`=0 → go to GATED and clear `clk_en_o`.
  - Gating is never granted while `core_busy_i`=1; the request simply waits.
- GATED:
  - `clk_gate_req_i`=0 → go to RUN and set `clk_en_o`=1.
  - `fetch_enable_i`=0 → go to IDLE with `clk_en_o`=1 and `fetch_enable_o`=0.
  - If both occur in the same cycle, `fetch_enable_i`=0 wins.
- `boot_addr_o` changes only on the IDLE→RUN transition. Changes on `boot_addr_i` in other states are ignored.
- `clk_en_o` is 1 in LOCK_WAIT, IDLE and RUN. `testmode_i`=1 forces `clk_en_o`=1 combinationally in every state.
- Priority in RUN/GATED: lock loss (if compiled in) > fetch_enable_i deassert > gating request.

## Timing
- All outputs except the testmode override on `clk_en_o` are registered.
- With `fll_lock_i` continuously 1 from reset release, ready_o rises after exactly LOCK_CYCLES rising edges.
- fetch_enable_o rises 1 cycle after `fetch_enable_i` is sampled high in IDLE. It falls 1 cycle after `fetch_enable_i` is sampled low.
- Gate grant latency: 1 cycle from the first cycle where the request is high and `core_busy_i` is low. Ungate latency: 1 cycle.
- Asynchronous reset mid-operation immediately restores every reset value. It also discards the latched boot address and the sticky flag.

## Configuration
- CORE_BOOT_CTRL_LOCK_LOSS_EN defined:
  - In RUN or GATED, a cycle with `fll_lock_i`=0 and `testmode_i`=0 causes, on the next edge: state = LOCK_WAIT, counter = 0, fetch_enable_o = 0, clk_en_o = 1, ready_o = 0, lock_lost_o = 1.
  - lock_lost_o stays at 1 until reset.
- Macro undefined:
  - After the first entry into IDLE, `fll_lock_i` is ignored.
  - lock_lost_o is constant 0.

## Test plan
- LOCK_CYCLES=16, lock held at 1 from reset release → ready_o=1 after edge 16, not before. fetch_enable_i=1 with boot_addr_i=32'h0000_0080 → next cycle fetch_enable_o=1 and boot_addr_o=32'h0000_0080.
- Lock high for 10 cycles, low for 1 cycle, then high → ready_o rises 16 cycles after the re-assertion.
- RUN with core_busy_i=1 and clk_gate_req_i=1 for 5 cycles → clk_en_o stays 1. core_busy_i drops → clk_en_o=0 next cycle. Request drops → clk_en_o=1 next cycle.
- In GATED, drop fetch_enable_i and clk_gate_req_i in the same cycle → next cycle IDLE, fetch_enable_o=0, clk_en_o=1.
- With the macro defined, drop lock for 1 cycle in RUN → fetch_enable_o=0, lock_lost_o=1, ready_o=0; restart requires 16 lock cycles. With the macro undefined, the same stimulus leaves fetch_enable_o=1 and lock_lost_o=0.
- testmode_i=1 with fll_lock_i=0 → ready_o after 16 cycles; clk_en_o=1 even with a gate request granted. Assert rst_n low while in RUN → all outputs return to reset values immediately.

Source files
------------

// File: rtl/core_boot_ctrl_if.sv
// ============================================================================
// Module   : core_boot_ctrl_if
// Desc     : Run-control bundle between the peripheral subsystem, the boot
//            controller (slave) and the core region.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface core_boot_ctrl_if;
    logic        testmode_i;
    logic        fll_lock_i;
    logic        fetch_enable_i;
    logic [31:0] boot_addr_i;
    logic        clk_gate_req_i;
    logic        core_busy_i;
    logic        fetch_enable_o;
    logic [31:0] boot_addr_o;
    logic        clk_en_o;
    logic        ready_o;
    logic        lock_lost_o;

    modport slave (
        input  testmode_i, fll_lock_i, fetch_enable_i, boot_addr_i,
               clk_gate_req_i, core_busy_i,
        output fetch_enable_o, boot_addr_o, clk_en_o, ready_o, lock_lost_o
    );

    modport master (
        output testmode_i, fll_lock_i, fetch_enable_i, boot_addr_i,
               clk_gate_req_i, core_busy_i,
        input  fetch_enable_o, boot_addr_o, clk_en_o, ready_o, lock_lost_o
    );
endinterface

`default_nettype wire

// File: rtl/core_boot_ctrl.sv
// ============================================================================
// Module   : core_boot_ctrl
// Desc     : Holds the core off until FLL lock is stable, then forwards fetch
//            enable with a latched boot address and arbitrates clock gating.
// Optional : CORE_BOOT_CTRL_LOCK_LOSS_EN - park the core on loss of lock.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module core_boot_ctrl #(
    parameter int unsigned LOCK_CYCLES     = 16,
    parameter logic [31:0] RESET_BOOT_ADDR = 32'h0000_0000
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    core_boot_ctrl_if.slave bus
);

    localparam int unsigned          c_CNT_W    = $clog2(LOCK_CYCLES + 1);
    localparam logic [c_CNT_W-1:0]   c_CNT_LAST = c_CNT_W'(LOCK_CYCLES - 1);
    localparam logic [c_CNT_W-1:0]   c_CNT_MAX  = c_CNT_W'(LOCK_CYCLES);

    typedef enum logic [1:0] {
        S_LOCK_WAIT = 2'd0,
        S_IDLE      = 2'd1,
        S_RUN       = 2'd2,
        S_GATED     = 2'd3
    } state_t;

    state_t              r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_fetch_en;
    logic [31:0]         r_boot_addr;
    logic                r_clk_en;
    logic                r_ready;
    logic                r_lock_lost;
    logic                w_lock_eff;

    assign w_lock_eff = bus.fll_lock_i | bus.testmode_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_LOCK_WAIT;
            r_cnt       <= '0;
            r_fetch_en  <= 1'b0;
            r_boot_addr <= RESET_BOOT_ADDR;
            r_clk_en    <= 1'b1;
            r_ready     <= 1'b0;
            r_lock_lost <= 1'b0;
        end else begin
            case (r_state)
                S_LOCK_WAIT: begin
                    if (!w_lock_eff) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        r_ready <= 1'b1;
                    end else if (r_cnt != c_CNT_MAX) begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                S_IDLE: begin
                    if (bus.fetch_enable_i) begin
                        r_boot_addr <= bus.boot_addr_i;
                        r_fetch_en  <= 1'b1;
                        r_state     <= S_RUN;
                    end
                end
                S_RUN: begin
`ifdef CORE_BOOT_CTRL_LOCK_LOSS_EN
                    if (!w_lock_eff) begin
                        r_state     <= S_LOCK_WAIT;
                        r_cnt       <= '0;
                        r_fetch_en  <= 1'b0;
                        r_clk_en    <= 1'b1;
                        r_ready     <= 1'b0;
                        r_lock_lost <= 1'b1;
                    end else
`endif
                    if (!bus.fetch_enable_i) begin
                        r_fetch_en <= 1'b0;
                        r_state    <= S_IDLE;
                    end else if (bus.clk_gate_req_i && !bus.core_busy_i) begin
                        r_clk_en <= 1'b0;
                        r_state  <= S_GATED;
                    end
                end
                S_GATED: begin
`ifdef CORE_BOOT_CTRL_LOCK_LOSS_EN
                    if (!w_lock_eff) begin
                        r_state     <= S_LOCK_WAIT;
                        r_cnt       <= '0;
                        r_fetch_en  <= 1'b0;
                        r_clk_en    <= 1'b1;
                        r_ready     <= 1'b0;
                        r_lock_lost <= 1'b1;
                    end else
`endif
                    // Dropping fetch enable wins over an ungate in the same cycle.
                    if (!bus.fetch_enable_i) begin
                        r_fetch_en <= 1'b0;
                        r_clk_en   <= 1'b1;
                        r_state    <= S_IDLE;
                    end else if (!bus.clk_gate_req_i) begin
                        r_clk_en <= 1'b1;
                        r_state  <= S_RUN;
                    end
                end
                default: begin
                    r_state <= S_LOCK_WAIT;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.fetch_enable_o = r_fetch_en;
    assign bus.boot_addr_o    = r_boot_addr;
    assign bus.clk_en_o       = r_clk_en | bus.testmode_i;
    assign bus.ready_o        = r_ready;
`ifdef CORE_BOOT_CTRL_LOCK_LOSS_EN
    assign bus.lock_lost_o    = r_lock_lost;
`else
    assign bus.lock_lost_o    = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_core_boot_ctrl.sv
// ============================================================================
// Module   : tb_core_boot_ctrl
// Desc     : Directed and randomized checks of core_boot_ctrl against a
//            behavioural model of the boot/run-control rules.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_core_boot_ctrl;

    localparam int          LOCK_CYCLES = 16;
    localparam logic [31:0] RST_ADDR    = 32'h0000_0000;
`ifdef CORE_BOOT_CTRL_LOCK_LOSS_EN
    localparam bit c_LOSS_EN = 1'b1;
`else
    localparam bit c_LOSS_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    core_boot_ctrl_if bus ();

    core_boot_ctrl #(
        .LOCK_CYCLES     (LOCK_CYCLES),
        .RESET_BOOT_ADDR (RST_ADDR)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: "streak" of stable-lock cycles; ready once the streak hits N.
    bit          m_ready, m_fe, m_gated, m_lost;
    int          m_streak;
    logic [31:0] m_addr;

    task automatic model_reset();
        m_ready = 0; m_fe = 0; m_gated = 0; m_lost = 0; m_streak = 0; m_addr = RST_ADDR;
    endtask

    task automatic model_edge();
        bit lock;
        lock = bus.fll_lock_i | bus.testmode_i;
        if (!m_ready) begin
            m_streak = lock ? m_streak + 1 : 0;
            if (m_streak == LOCK_CYCLES) begin
                m_ready  = 1;
                m_streak = 0;
            end
        end else if (m_fe) begin
            if (c_LOSS_EN && !lock) begin
                m_ready = 0; m_fe = 0; m_gated = 0; m_lost = 1; m_streak = 0;
            end else if (!bus.fetch_enable_i) begin
                m_fe = 0; m_gated = 0;
            end else if (m_gated) begin
                m_gated = bus.clk_gate_req_i;
            end else begin
                m_gated = bus.clk_gate_req_i && !bus.core_busy_i;
            end
        end else if (bus.fetch_enable_i) begin
            m_fe   = 1;
            m_addr = bus.boot_addr_i;
        end
    endtask

    task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        cmp({tag, ".fetch_enable_o"}, 32'(bus.fetch_enable_o), 32'(m_fe));
        cmp({tag, ".boot_addr_o"},    bus.boot_addr_o,         m_addr);
        cmp({tag, ".clk_en_o"},       32'(bus.clk_en_o),       32'(!m_gated || bus.testmode_i));
        cmp({tag, ".ready_o"},        32'(bus.ready_o),        32'(m_ready));
        cmp({tag, ".lock_lost_o"},    32'(bus.lock_lost_o),    32'(m_lost));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        rst_n = 1'b0;
        bus.testmode_i = 0; bus.fll_lock_i = 0; bus.fetch_enable_i = 0;
        bus.boot_addr_i = '0; bus.clk_gate_req_i = 0; bus.core_busy_i = 0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Lock held from reset release: ready exactly at edge LOCK_CYCLES.
        bus.fll_lock_i = 1;
        for (int i = 1; i <= LOCK_CYCLES; i++) step("lock_hold");
        cmp("ready_at_edge16", 32'(bus.ready_o), 32'd1);
        bus.fetch_enable_i = 1; bus.boot_addr_i = 32'h0000_0080;
        step("boot");
        cmp("boot_fe", 32'(bus.fetch_enable_o), 32'd1);
        cmp("boot_addr", bus.boot_addr_o, 32'h0000_0080);
        bus.boot_addr_i = 32'hDEAD_BEEF;
        step("addr_ignored_in_run");

        // Lock glitch restarts the qualification window.
        do_reset("reset_glitch");
        bus.fetch_enable_i = 0;
        for (int i = 0; i < 10; i++) step("glitch_pre");
        bus.fll_lock_i = 0;
        step("glitch_low");
        bus.fll_lock_i = 1;
        for (int i = 1; i < LOCK_CYCLES; i++) step("glitch_post");
        cmp("ready_before_16", 32'(bus.ready_o), 32'd0);
        step("glitch_ready");
        cmp("ready_after_16", 32'(bus.ready_o), 32'd1);

        // Gating held off while busy, then grant and release.
        bus.fetch_enable_i = 1; bus.boot_addr_i = 32'h0000_1000;
        step("run2");
        bus.core_busy_i = 1; bus.clk_gate_req_i = 1;
        for (int i = 0; i < 5; i++) step("busy_hold");
        cmp("busy_clk_en", 32'(bus.clk_en_o), 32'd1);
        bus.core_busy_i = 0;
        step("gate_grant");
        cmp("gated_clk_en", 32'(bus.clk_en_o), 32'd0);
        bus.clk_gate_req_i = 0;
        step("ungate");
        cmp("ungated_clk_en", 32'(bus.clk_en_o), 32'd1);

        // Fetch-enable drop beats ungate in the same cycle.
        bus.clk_gate_req_i = 1;
        step("regate");
        bus.clk_gate_req_i = 0; bus.fetch_enable_i = 0;
        step("gated_to_idle");
        cmp("idle_fe", 32'(bus.fetch_enable_o), 32'd0);
        cmp("idle_clk_en", 32'(bus.clk_en_o), 32'd1);

        // One-cycle lock loss in RUN.
        bus.fetch_enable_i = 1;
        step("run3");
        bus.fll_lock_i = 0;
        step("lock_drop");
        cmp("lock_drop_fe", 32'(bus.fetch_enable_o), c_LOSS_EN ? 32'd0 : 32'd1);
        cmp("lock_drop_lost", 32'(bus.lock_lost_o), c_LOSS_EN ? 32'd1 : 32'd0);
        bus.fll_lock_i = 1;
        for (int i = 0; i < LOCK_CYCLES + 2; i++) step("after_drop");

        // Test mode: no FLL lock needed, clock never gated.
        do_reset("reset_tm");
        bus.testmode_i = 1; bus.fll_lock_i = 0; bus.fetch_enable_i = 0;
        for (int i = 0; i < LOCK_CYCLES; i++) step("tm_lock");
        bus.fetch_enable_i = 1; bus.clk_gate_req_i = 1; bus.core_busy_i = 0;
        for (int i = 0; i < 3; i++) step("tm_gate");
        cmp("tm_clk_en", 32'(bus.clk_en_o), 32'd1);
        bus.clk_gate_req_i = 0;
        step("tm_ungate");
        do_reset("reset_in_run");
        bus.testmode_i = 0;

        // Randomized traffic with occasional asynchronous resets.
        for (int n = 0; n < 600; n++) begin
            bus.fll_lock_i     = ($urandom_range(0, 15) != 0);
            bus.testmode_i     = ($urandom_range(0, 31) == 0);
            bus.fetch_enable_i = ($urandom_range(0, 7) != 0);
            bus.boot_addr_i    = $urandom;
            bus.clk_gate_req_i = $urandom_range(0, 1) == 1;
            bus.core_busy_i    = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 199) == 0) do_reset("rand_reset");
            else step("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
